// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Drives a 3-input combinational netlist through all 8 input rows, holds each row for
// SETTLE_CYCLES cycles, samples the netlist output and assembles the measured truth table
// in Cello order (row 000 in the MSB). The table is compared against EXPECTED at the end
// of the sweep. Any output change between the last two settle cycles of a row is flagged.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   start      sweep request, sampled only when idle
//   dut_in1    netlist input in1 (row bit 2)
//   dut_in2    netlist input in2 (row bit 1)
//   dut_in3    netlist input in3 (row bit 0)
//   dut_out    netlist output, synchronous to clk
//   busy       high while a sweep is in progress
//   done       one-cycle pulse when a sweep completes
//   table_out  measured truth table, bit (7-r) holds row r
//   glitch     sticky flag: output unstable at sample time in some row
//   pass       table_out == EXPECTED and no glitch; valid from done until next start
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  EXPECTED      = 8'hF6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       dut_in1,
  output logic       dut_in2,
  output logic       dut_in3,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       glitch,
  output logic       pass
);

  if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 255) begin : gen_bad_settle
    $error("truth_table_sweeper: SETTLE_CYCLES must be in 2..255");
  end

  localparam logic [7:0] CntPrev   = 8'(SETTLE_CYCLES - 2);
  localparam logic [7:0] CntSample = 8'(SETTLE_CYCLES - 1);

  typedef enum logic {StIdle, StSweep} state_e;

  state_e     state_q, state_d;
  logic [2:0] row_q, row_d;
  logic [7:0] cnt_q, cnt_d;
  logic       prev_q, prev_d;
  logic [2:0] din_q, din_d;
  logic       done_q, done_d;
  logic [7:0] table_q, table_d;
  logic       glitch_q, glitch_d;
  logic       pass_q, pass_d;

  logic sample_now;
  logic last_row;

  assign sample_now = (state_q == StSweep) && (cnt_q == CntSample);
  assign last_row   = (row_q == 3'd7);

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      row_q    <= 3'd0;
      cnt_q    <= 8'd0;
      prev_q   <= 1'b0;
      din_q    <= 3'd0;
      done_q   <= 1'b0;
      table_q  <= 8'h00;
      glitch_q <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      din_q    <= din_d;
      done_q   <= done_d;
      table_q  <= table_d;
      glitch_q <= glitch_d;
      pass_q   <= pass_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StSweep;
      StSweep: if (sample_now && last_row) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath / registered-output next values
  always_comb begin
    row_d    = row_q;
    cnt_d    = cnt_q;
    prev_d   = prev_q;
    din_d    = din_q;
    done_d   = 1'b0;
    table_d  = table_q;
    glitch_d = glitch_q;
    pass_d   = pass_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          row_d    = 3'd0;
          cnt_d    = 8'd0;
          din_d    = 3'd0;
          table_d  = 8'h00;
          glitch_d = 1'b0;
          pass_d   = 1'b0;
        end
      end
      StSweep: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == CntPrev) prev_d = dut_out;
        if (sample_now) begin
          // Cello order: row r lands in bit 7-r, i.e. the bitwise inverse of r
          table_d[~row_q] = dut_out;
          glitch_d        = glitch_q | (dut_out != prev_q);
          cnt_d           = 8'd0;
          if (last_row) begin
            row_d  = 3'd0;
            din_d  = 3'd0;
            done_d = 1'b1;
            pass_d = (table_d == EXPECTED) && !glitch_d;
          end else begin
            row_d = row_q + 3'd1;
            din_d = row_q + 3'd1;
          end
        end
      end
      default: ;
    endcase
  end

  assign dut_in1   = din_q[2];
  assign dut_in2   = din_q[1];
  assign dut_in3   = din_q[0];
  assign busy      = (state_q == StSweep);
  assign done      = done_q;
  assign table_out = table_q;
  assign glitch    = glitch_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       dut_in1, dut_in2, dut_in3;
  logic       dut_out;
  logic       busy, done, glitch, pass;
  logic [7:0] table_out;

  // Netlist model: 0 = ~in1 | (in2^in3), 1 = tied 0, 2 = tied 1; inv forces an inversion
  logic [1:0] mode = 2'd0;
  logic       inv  = 1'b0;
  logic       model_out;

  always #5 clk = ~clk;

  always_comb begin
    model_out = 1'b0;
    case (mode)
      2'd0:    model_out = ~dut_in1 | (dut_in2 ^ dut_in3);
      2'd1:    model_out = 1'b0;
      default: model_out = 1'b1;
    endcase
    dut_out = model_out ^ inv;
  end

  truth_table_sweeper #(
    .SETTLE_CYCLES(4),
    .EXPECTED     (8'hF6)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dut_in1  (dut_in1),
    .dut_in2  (dut_in2),
    .dut_in3  (dut_in3),
    .dut_out  (dut_out),
    .busy     (busy),
    .done     (done),
    .table_out(table_out),
    .glitch   (glitch),
    .pass     (pass)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] tbl;
    logic       pass;
    logic       glitch;
  } exp_t;

  typedef struct {
    logic [1:0] mode;
    logic       inv_row3;
    int         restart_at;
    logic [7:0] exp_table;
    logic       exp_pass;
    logic       exp_glitch;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[5];

  // Scoreboard consumer: one expectation per done pulse
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("table_out", 32'(table_out), 32'(mon_e.tbl));
        chk("pass", 32'(pass), 32'(mon_e.pass));
        chk("glitch", 32'(glitch), 32'(mon_e.glitch));
      end
    end
  end

  function automatic exp_t mk_exp(input logic [7:0] t, input logic p, input logic g);
    exp_t e;
    e.tbl    = t;
    e.pass   = p;
    e.glitch = g;
    return e;
  endfunction

  // Start a sweep, then follow it edge by edge; n counts edges after acceptance edge T
  task automatic run_sweep(input vec_t v);
    int n;
    int d0;
    n    = 0;
    d0   = done_cnt;
    mode = v.mode;
    sb_q.push_back(mk_exp(v.exp_table, v.exp_pass, v.exp_glitch));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("table_cleared", 32'(table_out), 32'h00);
    while (n < 100) begin
      @(negedge clk);
      n++;
      // c == 2 of row 3 is the cycle after edge T+14
      inv   = v.inv_row3 && (n == 14);
      start = (n == v.restart_at);
      if (done) break;
    end
    inv   = 1'b0;
    start = 1'b0;
    chk("done_latency", 32'(n), 32'd32);
    chk("dut_in_idle", 32'({dut_in1, dut_in2, dut_in3}), 32'd0);
    chk("busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("single_done", 32'(done_cnt), 32'(d0 + 1));
  endtask

  initial begin
    int n;
    int d0;
    int nd;

    vecs[0] = '{mode: 2'd0, inv_row3: 1'b0, restart_at: 0,  exp_table: 8'hF6,
                exp_pass: 1'b1, exp_glitch: 1'b0};
    vecs[1] = '{mode: 2'd1, inv_row3: 1'b0, restart_at: 0,  exp_table: 8'h00,
                exp_pass: 1'b0, exp_glitch: 1'b0};
    vecs[2] = '{mode: 2'd2, inv_row3: 1'b0, restart_at: 0,  exp_table: 8'hFF,
                exp_pass: 1'b0, exp_glitch: 1'b0};
    vecs[3] = '{mode: 2'd0, inv_row3: 1'b1, restart_at: 0,  exp_table: 8'hF6,
                exp_pass: 1'b0, exp_glitch: 1'b1};
    vecs[4] = '{mode: 2'd0, inv_row3: 1'b0, restart_at: 10, exp_table: 8'hF6,
                exp_pass: 1'b1, exp_glitch: 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_table", 32'(table_out), 32'h00);
    chk("rst_glitch", 32'(glitch), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_dut_in", 32'({dut_in1, dut_in2, dut_in3}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_sweep(vecs[i]);

    // Reset in the middle of row 4
    mode = 2'd0;
    d0   = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_table_partial", 32'(table_out), 32'hF0);
    chk("mid_dut_in_row4", 32'({dut_in1, dut_in2, dut_in3}), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_table", 32'(table_out), 32'h00);
    chk("async_rst_dut_in", 32'({dut_in1, dut_in2, dut_in3}), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_done_after_rst", 32'(done_cnt), 32'(d0));
    chk("idle_after_rst", 32'(busy), 32'd0);
    run_sweep(vecs[0]);

    // Start held high: back-to-back sweeps
    mode = 2'd0;
    for (int i = 0; i < 3; i++) sb_q.push_back(mk_exp(8'hF6, 1'b1, 1'b0));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n  = 0;
    nd = 0;
    while (n < 120 && nd < 3) begin
      @(negedge clk);
      n++;
      if (done) begin
        chk("b2b_done_time", 32'(n), 32'(32 + 33 * nd));
        nd++;
        if (nd == 3) start = 1'b0;
      end
      if (nd < 3 && (n == 33 || n == 66)) begin
        chk("b2b_restart_busy", 32'(busy), 32'd1);
        chk("b2b_table_cleared", 32'(table_out), 32'h00);
      end
    end
    start = 1'b0;
    chk("b2b_done_count", 32'(nd), 32'd3);
    @(negedge clk);
    chk("b2b_idle", 32'(busy), 32'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
